// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width and receive FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_WORD_WIDTH = 32;
  localparam int unsigned SPI_STATE_W    = 2;

  typedef enum logic [SPI_STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_rx_shift.sv
// MSB-first receive shift register with bit counter; last_bit_c flags that the
// shift taken on this edge completes a WIDTH-bit word.
module spi_rx_shift
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WORD_WIDTH
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             sdi,
  output logic [WIDTH-1:0] word,
  output logic             last_bit_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear wins over shift; the FSM never asserts both
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], sdi};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word       = shreg_q;
  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/spi_0i_32o.sv
// SPI receive-only deserialiser: frames of exactly WIDTH bits update pdo and
// pulse data_valid; shorter or longer frames pulse frame_error.
module spi_0i_32o
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = SPI_WORD_WIDTH,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                cs,
  input  logic                sdi,
  output logic [WIDTH-1:0]    pdo,
  output logic                data_valid,
  output logic                frame_error,
  output logic [CNT_BITS-1:0] frame_count
);

  spi_state_e          state_q, state_d;
  logic [WIDTH-1:0]    pdo_q, pdo_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_error_q, frame_error_d;
  logic [CNT_BITS-1:0] frame_count_q, frame_count_d;

  logic             shift_en_c;
  logic             clear_c;
  logic             last_bit_c;
  logic [WIDTH-1:0] word;

  spi_rx_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .sclk       (sclk),
    .reset      (reset),
    .shift_en   (shift_en_c),
    .clear      (clear_c),
    .sdi        (sdi),
    .word       (word),
    .last_bit_c (last_bit_c)
  );

  // sdi is only consumed through shift_en_c, which requires cs low
  always_comb begin
    state_d       = state_q;
    pdo_d         = pdo_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    frame_count_d = frame_count_q;
    shift_en_c    = 1'b0;
    clear_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs) begin
          shift_en_c = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!cs) begin
          shift_en_c = 1'b1;
          if (last_bit_c) state_d = ST_FULL;
        end else begin
          frame_error_d = 1'b1;
          clear_c       = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (cs) begin
          pdo_d         = word;
          data_valid_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_BITS'(1);
          clear_c       = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          frame_error_d = 1'b1;
          state_d       = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (cs) begin
          clear_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pdo_q         <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pdo_q         <= pdo_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pdo         = pdo_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_0i_32o.sv
// Directed self-checking bench for the SPI receive deserialiser.
module tb_spi_0i_32o;

  logic        sclk;
  logic        reset;
  logic        cs;
  logic        sdi;
  logic [31:0] pdo;
  logic        data_valid;
  logic        frame_error;
  logic [7:0]  frame_count;

  int vectors;
  int miscompares;

  spi_0i_32o #(
    .WIDTH    (32),
    .CNT_BITS (8)
  ) dut (
    .sclk        (sclk),
    .reset       (reset),
    .cs          (cs),
    .sdi         (sdi),
    .pdo         (pdo),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .frame_count (frame_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Shift nbits of data MSB first with cs low; tally pulses seen after each edge.
  task automatic send_bits(input logic [63:0] data, input int nbits,
                           output int dv_n, output int fe_n, output int fe_last);
    dv_n    = 0;
    fe_n    = 0;
    fe_last = 0;
    for (int k = 0; k < nbits; k++) begin
      cs  = 1'b0;
      sdi = data[nbits-1-k];
      step();
      if (data_valid)  dv_n++;
      if (frame_error) begin
        fe_n++;
        fe_last = k + 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cs    = 1'b1;
    sdi   = 1'bx;
    repeat (3) step();
    vectors++;
    if (pdo !== 32'h0 || data_valid !== 1'b0 || frame_error !== 1'b0 || frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: pdo=%h dv=%b fe=%b cnt=%0d, want 0/0/0/0",
               pdo, data_valid, frame_error, frame_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    int dv_n, fe_n, fe_last;
    send_bits(64'hDEADBEEF, 32, dv_n, fe_n, fe_last);
    vectors++;
    if (dv_n !== 0 || fe_n !== 0) begin
      miscompares++;
      $display("FAIL good_during: dv=%0d fe=%0d pulses, want 0/0", dv_n, fe_n);
    end
    cs  = 1'b1;
    sdi = 1'bx;
    step();
    vectors++;
    if (data_valid !== 1'b1 || frame_error !== 1'b0 || pdo !== 32'hDEADBEEF || frame_count !== 8'd1) begin
      miscompares++;
      $display("FAIL good_end: dv=%b fe=%b pdo=%h cnt=%0d, want 1/0/deadbeef/1",
               data_valid, frame_error, pdo, frame_count);
    end
    step();
    vectors++;
    if (data_valid !== 1'b0 || pdo !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL good_after: dv=%b pdo=%h, want 0/deadbeef", data_valid, pdo);
    end
  endtask

  task automatic test_short_frame();
    int dv_n, fe_n, fe_last;
    send_bits(64'hA5A5, 16, dv_n, fe_n, fe_last);
    cs  = 1'b1;
    sdi = 1'bx;
    step();
    vectors++;
    if (frame_error !== 1'b1 || data_valid !== 1'b0 || dv_n !== 0 || fe_n !== 0) begin
      miscompares++;
      $display("FAIL short_end: fe=%b dv=%b early dv/fe=%0d/%0d, want 1/0/0/0",
               frame_error, data_valid, dv_n, fe_n);
    end
    vectors++;
    if (pdo !== 32'hDEADBEEF || frame_count !== 8'd1) begin
      miscompares++;
      $display("FAIL short_hold: pdo=%h cnt=%0d, want deadbeef/1", pdo, frame_count);
    end
    step();
    vectors++;
    if (frame_error !== 1'b0) begin
      miscompares++;
      $display("FAIL short_pulse_width: fe=%b, want 0", frame_error);
    end
  endtask

  task automatic test_overlong_frame();
    int dv_n, fe_n, fe_last;
    send_bits(64'h1_0F0F_0F0F, 33, dv_n, fe_n, fe_last);
    vectors++;
    if (fe_n !== 1 || fe_last !== 33 || dv_n !== 0) begin
      miscompares++;
      $display("FAIL overlong_err: fe pulses=%0d at edge %0d dv=%0d, want 1 at 33, dv 0",
               fe_n, fe_last, dv_n);
    end
    cs  = 1'b1;
    sdi = 1'bx;
    step();
    vectors++;
    if (frame_error !== 1'b0 || data_valid !== 1'b0 || pdo !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL overlong_end: fe=%b dv=%b pdo=%h, want 0/0/deadbeef",
               frame_error, data_valid, pdo);
    end
    send_bits(64'h12345678, 32, dv_n, fe_n, fe_last);
    cs  = 1'b1;
    sdi = 1'bx;
    step();
    vectors++;
    if (data_valid !== 1'b1 || pdo !== 32'h12345678 || frame_count !== 8'd2) begin
      miscompares++;
      $display("FAIL overlong_next: dv=%b pdo=%h cnt=%0d, want 1/12345678/2",
               data_valid, pdo, frame_count);
    end
  endtask

  task automatic test_mid_reset();
    int dv_n, fe_n, fe_last;
    int pulses;
    send_bits(64'hCAFEF00D, 10, dv_n, fe_n, fe_last);
    reset = 1'b1;
    #1;
    vectors++;
    if (pdo !== 32'h0 || data_valid !== 1'b0 || frame_error !== 1'b0 || frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_async: pdo=%h dv=%b fe=%b cnt=%0d, want 0/0/0/0",
               pdo, data_valid, frame_error, frame_count);
    end
    cs  = 1'b1;
    sdi = 1'bx;
    pulses = 0;
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      if (data_valid || frame_error) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midreset_nopulse: %0d pulses, want 0", pulses);
    end
    send_bits(64'h1, 32, dv_n, fe_n, fe_last);
    cs  = 1'b1;
    sdi = 1'bx;
    step();
    vectors++;
    if (data_valid !== 1'b1 || pdo !== 32'h1 || frame_count !== 8'd1) begin
      miscompares++;
      $display("FAIL midreset_next: dv=%b pdo=%h cnt=%0d, want 1/00000001/1",
               data_valid, pdo, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    int dv_n, fe_n, fe_last;
    int dv_total;
    int fe_total;
    logic [31:0] expect_word;
    reset = 1'b1;
    cs    = 1'b1;
    step();
    reset    = 1'b0;
    dv_total = 0;
    fe_total = 0;
    for (int f = 0; f < 256; f++) begin
      expect_word = 32'h8000_0000 + 32'(f * 32'h0101_0101);
      send_bits({32'h0, expect_word}, 32, dv_n, fe_n, fe_last);
      dv_total += dv_n;
      fe_total += fe_n;
      cs  = 1'b1;
      sdi = 1'bx;
      step();
      if (data_valid) dv_total++;
      if (frame_error) fe_total++;
      vectors++;
      if (data_valid !== 1'b1 || pdo !== expect_word) begin
        miscompares++;
        $display("FAIL b2b_word[%0d]: dv=%b pdo=%h, want 1/%h", f, data_valid, pdo, expect_word);
      end
    end
    vectors++;
    if (dv_total !== 256 || fe_total !== 0 || frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_totals: dv=%0d fe=%0d cnt=%0d, want 256/0/0",
               dv_total, fe_total, frame_count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cs          = 1'b1;
    sdi         = 1'b0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overlong_frame();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
